hash_bank_ctrl: RTL and testbench
=================================

HASH_BANK_CTRL -- requirements
Module: hash_bank_ctrl

Interface
REQ-001 Parameter NUM_TABLES, default 3: number of hash tables (1..8).
REQ-002 Parameter BASE_DEPTH, default 2140: depth of table 0; table i depth = BASE_DEPTH >> i.
REQ-003 Parameter ADDR_W, default 12: address width of every table port (must cover BASE_DEPTH-1).
REQ-004 Parameter DATA_W, default 4: bucket counter width.
REQ-005 Sys_clk  in  1  single clock; all logic on rising edge.
REQ-006 Rst  in  1  reset, asynchronous and active-high.
REQ-007 Hash_valid  in  1  lookup request; all tables read in parallel.
REQ-008 Hash_add  in  NUM_TABLES*ADDR_W  lookup addresses, table i at bits [i*ADDR_W +: ADDR_W].
REQ-009 Hash_rdata  out  NUM_TABLES*DATA_W  lookup data, same packing.
REQ-010 Hash_rdata_wr  out  1  lookup data valid strobe.
REQ-011 Upd_valid  in  1  update request.
REQ-012 Upd_ready  out  1  update accepted when Upd_valid and Upd_ready both high.
REQ-013 Upd_table  in  3  target table index.
REQ-014 Upd_add  in  ADDR_W  target bucket address.
REQ-015 Upd_mode  in  1  0 = write Upd_data, 1 = increment by one.
REQ-016 Upd_data  in  DATA_W  write data (mode 0).
REQ-017 Upd_err  out  1  one-cycle pulse: accepted update was out of range.
REQ-018 Init_done  out  1  high once post-reset clear sweep has finished.

Function
REQ-019 Lookup latency SHALL be 2 cycles: Hash_valid at T gives Hash_rdata and Hash_rdata_wr=1 at T+2; back-to-back lookups every cycle.
REQ-020 Lookup address >= table i depth SHALL return 0 for that table's slot.
REQ-021 Hash_rdata SHALL hold its last value while Hash_rdata_wr=0.
REQ-022 Hash_valid SHALL be ignored while Init_done=0; no strobe is produced.
REQ-023 Upd_ready SHALL equal Init_done.
REQ-024 Update pipeline: accept at T, port-B read at T+1, port-B write at T+2; throughput one update per cycle.
REQ-025 Mode 0 SHALL write Upd_data; mode 1 SHALL write old value + 1.
REQ-026 Increment of an all-ones bucket SHALL follow REQ-041 (saturate or wrap).
REQ-027 An accepted update with Upd_table >= NUM_TABLES or Upd_add >= depth SHALL perform no write and pulse Upd_err at T+1.
REQ-028 Read-after-write hazard: an update matching table and address of an update in flight SHALL use the in-flight write value, never stale RAM data, so N back-to-back increments add exactly N.
REQ-029 A lookup and an update write to the same bucket in the same cycle SHALL return the pre-write value.
REQ-030 Controller FSM states CLEAR and RUN; CLEAR writes 0 to addresses 0..BASE_DEPTH-1 of every table (one address per cycle, all tables in parallel, skipping out-of-range), then moves to RUN and sets Init_done.
REQ-031 RUN SHALL be held until reset; no other transition.

Reset
REQ-032 Rst SHALL force FSM to CLEAR with sweep address 0, also when asserted mid-sweep or mid-update.
REQ-033 Reset values: Hash_rdata=0, Hash_rdata_wr=0, Upd_err=0, Init_done=0; in-flight updates discarded.
REQ-034 RAM contents are not reset directly; the CLEAR sweep zeroes them.

Configuration
REQ-040 Macro HASH_SAT_EN selects increment overflow behaviour.
REQ-041 With HASH_SAT_EN defined, increment of all-ones SHALL leave all-ones; without it, SHALL wrap to 0.

Structure
REQ-050 Package hash_bank_pkg SHALL hold the mode encoding (UPD_WRITE, UPD_INCR), FSM state typedef, and depth-of-table constant function.
REQ-051 One sub-module hash_bank_ram (true dual-port RAM, port A read-only lookup, port B read/write update, 1-cycle read) SHALL be instantiated NUM_TABLES times via generate.

Verification
REQ-060 Reset, wait BASE_DEPTH cycles -> Init_done=1 at cycle BASE_DEPTH+1; lookups of addresses 0, 534, 2139 return 0 in all tables.
REQ-061 Write table 1 addr 100 = 4'h9, then lookup addr 100 in all tables -> slot 1 = 9, slots 0 and 2 = 0, strobe 2 cycles after Hash_valid.
REQ-062 Five back-to-back increments, table 0 addr 7 -> later lookup returns 5.
REQ-063 Twenty increments, table 2 addr 3 -> 15 with HASH_SAT_EN, 4 without.
REQ-064 Update to table 2 addr 600 (depth 535) -> Upd_err pulse at T+1, no write; lookup table 2 addr 600 returns 0.
REQ-065 Assert Rst mid-sweep after 1000 cycles -> Init_done=0, full sweep restarts, previously written data reads 0.

Source files
------------

// File: rtl/hash_bank_pkg.sv
// Shared types and constants for the hash bank controller: update modes,
// controller states and per-table depth derivation.
package hash_bank_pkg;

    typedef enum logic {
        UPD_WRITE = 1'b0,
        UPD_INCR  = 1'b1
    } upd_mode_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } ctrl_state_e;

    // Table idx halves in depth per index; tables beyond num_tables have depth 0,
    // which makes every address out of range for them.
    function automatic int table_depth(input int base_depth, input int idx, input int num_tables);
        return (idx < num_tables) ? (base_depth >> idx) : 0;
    endfunction

endpackage

// File: rtl/hash_bank_ram.sv
// True dual-port bucket RAM: port A is a read-only lookup port, port B is the
// update port (independent read and write addresses). Both reads are 1-cycle, read-first.
module hash_bank_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [DATA_W-1:0] a_rdata,
    input  logic [ADDR_W-1:0] b_raddr,
    output logic [DATA_W-1:0] b_rdata,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_waddr,
    input  logic [DATA_W-1:0] b_wdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;
    logic              a_hit;
    logic              b_rhit;
    logic              b_whit;

    // Addresses past the table end read as zero and never write, so the
    // truncated index below can never alias onto a real bucket.
    assign a_hit  = {1'b0, a_addr}  < DEPTH_L;
    assign b_rhit = {1'b0, b_raddr} < DEPTH_L;
    assign b_whit = {1'b0, b_waddr} < DEPTH_L;

    always_ff @(posedge clk) begin
        a_rdata_q <= a_hit  ? mem_q[a_addr[IDX_W-1:0]]  : '0;
        b_rdata_q <= b_rhit ? mem_q[b_raddr[IDX_W-1:0]] : '0;
        if (b_we && b_whit) begin
            mem_q[b_waddr[IDX_W-1:0]] <= b_wdata;
        end
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/hash_bank_ctrl.sv
// Multi-table hash bucket controller: parallel 2-cycle lookups, pipelined
// write/increment updates with hazard forwarding. HASH_SAT_EN makes increments saturate.
module hash_bank_ctrl
    import hash_bank_pkg::*;
#(
    parameter int NUM_TABLES = 3,
    parameter int BASE_DEPTH = 2140,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 4
) (
    input  logic                         Sys_clk,
    input  logic                         Rst,
    input  logic                         Hash_valid,
    input  logic [NUM_TABLES*ADDR_W-1:0] Hash_add,
    output logic [NUM_TABLES*DATA_W-1:0] Hash_rdata,
    output logic                         Hash_rdata_wr,
    input  logic                         Upd_valid,
    output logic                         Upd_ready,
    input  logic [2:0]                   Upd_table,
    input  logic [ADDR_W-1:0]            Upd_add,
    input  logic                         Upd_mode,
    input  logic [DATA_W-1:0]            Upd_data,
    output logic                         Upd_err,
    output logic                         Init_done,
    output ctrl_state_e                  Dbg_state
);

    localparam logic [ADDR_W-1:0] SWEEP_LAST = ADDR_W'(BASE_DEPTH - 1);

    ctrl_state_e                  state_q, state_d;
    logic [ADDR_W-1:0]            sweep_q, sweep_d;
    logic                         init_done_q, init_done_d;

    logic                         l1_valid_q, l1_valid_d;
    logic [NUM_TABLES*DATA_W-1:0] rdata_q, rdata_d;
    logic                         rdata_wr_q, rdata_wr_d;

    logic                         u1_valid_q, u1_valid_d;
    logic [2:0]                   u1_tbl_q, u1_tbl_d;
    logic [ADDR_W-1:0]            u1_addr_q, u1_addr_d;
    upd_mode_e                    u1_mode_q, u1_mode_d;
    logic [DATA_W-1:0]            u1_data_q, u1_data_d;
    logic                         err_q, err_d;

    logic                         u2_valid_q, u2_valid_d;
    logic [2:0]                   u2_tbl_q, u2_tbl_d;
    logic [ADDR_W-1:0]            u2_addr_q, u2_addr_d;
    upd_mode_e                    u2_mode_q, u2_mode_d;
    logic [DATA_W-1:0]            u2_data_q, u2_data_d;

    logic                         lw_valid_q, lw_valid_d;
    logic [2:0]                   lw_tbl_q, lw_tbl_d;
    logic [ADDR_W-1:0]            lw_addr_q, lw_addr_d;
    logic [DATA_W-1:0]            lw_data_q, lw_data_d;

    logic [ADDR_W:0]              tbl_depth [8];
    logic [DATA_W-1:0]            a_rdata [NUM_TABLES];
    logic [DATA_W-1:0]            b_rdata [8];
    logic [NUM_TABLES-1:0]        b_we;
    logic [ADDR_W-1:0]            b_waddr;
    logic [DATA_W-1:0]            b_wdata;

    logic                         upd_acc;
    logic                         upd_oor;
    logic                         fwd_hit;
    logic [DATA_W-1:0]            old_val;
    logic [DATA_W-1:0]            incr_val;
    logic [DATA_W-1:0]            new_val;

    for (genvar g = 0; g < 8; g++) begin : g_tbl
        localparam logic [ADDR_W:0] DEP = (ADDR_W + 1)'(table_depth(BASE_DEPTH, g, NUM_TABLES));
        assign tbl_depth[g] = DEP;
        if (g < NUM_TABLES) begin : g_ram
            hash_bank_ram #(
                .DEPTH  (table_depth(BASE_DEPTH, g, NUM_TABLES)),
                .ADDR_W (ADDR_W),
                .DATA_W (DATA_W)
            ) u_ram (
                .clk     (Sys_clk),
                .a_addr  (Hash_add[g*ADDR_W +: ADDR_W]),
                .a_rdata (a_rdata[g]),
                .b_raddr (u1_addr_q),
                .b_rdata (b_rdata[g]),
                .b_we    (b_we[g]),
                .b_waddr (b_waddr),
                .b_wdata (b_wdata)
            );
            assign b_we[g] = (state_q == ST_CLEAR) ? ({1'b0, sweep_q} < DEP)
                                                   : (u2_valid_q && (u2_tbl_q == 3'(g)));
        end else begin : g_none
            assign b_rdata[g] = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_CLEAR: begin
                if (sweep_q == SWEEP_LAST) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            ST_RUN: state_d = ST_RUN;
        endcase

        l1_valid_d = Hash_valid && init_done_q;
        rdata_wr_d = l1_valid_q;
        rdata_d    = rdata_q;
        if (l1_valid_q) begin
            for (int i = 0; i < NUM_TABLES; i++) begin
                rdata_d[i*DATA_W +: DATA_W] = a_rdata[i];
            end
        end

        // Bad table indices map to depth 0, so one compare covers both error cases.
        upd_acc    = Upd_valid && init_done_q;
        upd_oor    = {1'b0, Upd_add} >= tbl_depth[Upd_table];
        u1_valid_d = upd_acc && !upd_oor;
        err_d      = upd_acc && upd_oor;
        u1_tbl_d   = Upd_table;
        u1_addr_d  = Upd_add;
        u1_mode_d  = upd_mode_e'(Upd_mode);
        u1_data_d  = Upd_data;

        u2_valid_d = u1_valid_q;
        u2_tbl_d   = u1_tbl_q;
        u2_addr_d  = u1_addr_q;
        u2_mode_d  = u1_mode_q;
        u2_data_d  = u1_data_q;

        // The write retired on the previous edge landed as this op's port-B read
        // was sampled, so the RAM word is stale; take the retired value instead.
        fwd_hit = lw_valid_q && (lw_tbl_q == u2_tbl_q) && (lw_addr_q == u2_addr_q);
        old_val = fwd_hit ? lw_data_q : b_rdata[u2_tbl_q];
`ifdef HASH_SAT_EN
        incr_val = (&old_val) ? old_val : old_val + 1'b1;
`else
        incr_val = old_val + 1'b1;
`endif
        new_val = (u2_mode_q == UPD_INCR) ? incr_val : u2_data_q;

        lw_valid_d = u2_valid_q;
        lw_tbl_d   = u2_tbl_q;
        lw_addr_d  = u2_addr_q;
        lw_data_d  = new_val;

        b_waddr = (state_q == ST_CLEAR) ? sweep_q : u2_addr_q;
        b_wdata = (state_q == ST_CLEAR) ? '0 : new_val;
    end

    always_ff @(posedge Sys_clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= ST_CLEAR;
            sweep_q     <= '0;
            init_done_q <= 1'b0;
            l1_valid_q  <= 1'b0;
            rdata_q     <= '0;
            rdata_wr_q  <= 1'b0;
            u1_valid_q  <= 1'b0;
            u1_tbl_q    <= '0;
            u1_addr_q   <= '0;
            u1_mode_q   <= UPD_WRITE;
            u1_data_q   <= '0;
            err_q       <= 1'b0;
            u2_valid_q  <= 1'b0;
            u2_tbl_q    <= '0;
            u2_addr_q   <= '0;
            u2_mode_q   <= UPD_WRITE;
            u2_data_q   <= '0;
            lw_valid_q  <= 1'b0;
            lw_tbl_q    <= '0;
            lw_addr_q   <= '0;
            lw_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            init_done_q <= init_done_d;
            l1_valid_q  <= l1_valid_d;
            rdata_q     <= rdata_d;
            rdata_wr_q  <= rdata_wr_d;
            u1_valid_q  <= u1_valid_d;
            u1_tbl_q    <= u1_tbl_d;
            u1_addr_q   <= u1_addr_d;
            u1_mode_q   <= u1_mode_d;
            u1_data_q   <= u1_data_d;
            err_q       <= err_d;
            u2_valid_q  <= u2_valid_d;
            u2_tbl_q    <= u2_tbl_d;
            u2_addr_q   <= u2_addr_d;
            u2_mode_q   <= u2_mode_d;
            u2_data_q   <= u2_data_d;
            lw_valid_q  <= lw_valid_d;
            lw_tbl_q    <= lw_tbl_d;
            lw_addr_q   <= lw_addr_d;
            lw_data_q   <= lw_data_d;
        end
    end

    // Upd_valid/Upd_ready: an update transfers on any rising edge where both are high.
    assign Upd_ready     = init_done_q;
    assign Init_done     = init_done_q;
    assign Upd_err       = err_q;
    assign Hash_rdata    = rdata_q;
    assign Hash_rdata_wr = rdata_wr_q;
    assign Dbg_state     = state_q;

endmodule

// File: tb/tb_hash_bank_ctrl.sv
// Scoreboard bench for hash_bank_ctrl: directed lookups/updates with hand-computed
// results; monitors check lookup strobes, held data and Upd_err pulses every cycle.
module tb_hash_bank_ctrl;
    import hash_bank_pkg::*;

    localparam int NT = 3;
    localparam int BD = 2140;
    localparam int AW = 12;
    localparam int DW = 4;
    localparam int RW = NT * DW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            hash_valid = 1'b0;
    logic [NT*AW-1:0] hash_add = '0;
    logic [RW-1:0]   hash_rdata;
    logic            hash_rdata_wr;
    logic            upd_valid = 1'b0;
    logic            upd_ready;
    logic [2:0]      upd_table = '0;
    logic [AW-1:0]   upd_add = '0;
    logic            upd_mode = 1'b0;
    logic [DW-1:0]   upd_data = '0;
    logic            upd_err;
    logic            init_done;
    ctrl_state_e     dbg_state;

    always #5 clk = ~clk;

    hash_bank_ctrl #(
        .NUM_TABLES (NT),
        .BASE_DEPTH (BD),
        .ADDR_W     (AW),
        .DATA_W     (DW)
    ) dut (
        .Sys_clk       (clk),
        .Rst           (rst),
        .Hash_valid    (hash_valid),
        .Hash_add      (hash_add),
        .Hash_rdata    (hash_rdata),
        .Hash_rdata_wr (hash_rdata_wr),
        .Upd_valid     (upd_valid),
        .Upd_ready     (upd_ready),
        .Upd_table     (upd_table),
        .Upd_add       (upd_add),
        .Upd_mode      (upd_mode),
        .Upd_data      (upd_data),
        .Upd_err       (upd_err),
        .Init_done     (init_done),
        .Dbg_state     (dbg_state)
    );

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            rel_cyc = 0;
    logic [RW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    logic          exp_err_q[$];
    logic [RW-1:0] last_rdata = '0;
    logic [RW-1:0] mon_exp;
    logic          mon_strobe;
    logic          mon_err;
    logic          acc_seen = 1'b0;

`ifdef HASH_SAT_EN
    localparam logic [DW-1:0] INC20 = 4'hF;
`else
    localparam logic [DW-1:0] INC20 = 4'h4;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        acc_seen = !rst && upd_valid && (upd_ready === 1'b1);
    end

    // Monitor: strobe timing, lookup data, hold behaviour and Upd_err pulses.
    always @(negedge clk) begin
        if (rst) begin
            last_rdata = '0;
        end else begin
            mon_strobe = (exp_cyc_q.size() != 0) && (exp_cyc_q[0] == cyc);
            check("lookup_strobe", hash_rdata_wr, mon_strobe);
            if (mon_strobe) begin
                mon_exp = exp_q.pop_front();
                void'(exp_cyc_q.pop_front());
                check("lookup_data", hash_rdata, mon_exp);
                last_rdata = mon_exp;
            end else begin
                check("rdata_hold", hash_rdata, last_rdata);
            end
            mon_err = 1'b0;
            if (acc_seen && exp_err_q.size() != 0) mon_err = exp_err_q.pop_front();
            check("upd_err", upd_err, mon_err);
        end
    end

    task automatic lookup(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                          input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        hash_add   = {a2, a1, a0};
        hash_valid = 1'b1;
        exp_q.push_back({e2, e1, e0});
        exp_cyc_q.push_back(cyc + 2);
        @(negedge clk);
        hash_valid = 1'b0;
    endtask

    task automatic upd(input logic [2:0] t, input logic [AW-1:0] a, input logic m,
                       input logic [DW-1:0] d, input logic e);
        upd_table = t;
        upd_add   = a;
        upd_mode  = m;
        upd_data  = d;
        upd_valid = 1'b1;
        exp_err_q.push_back(e);
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_init(input int rel);
        int guard;
        guard = 0;
        while (init_done !== 1'b1 && guard < BD + 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("init_cycles", cyc - rel, BD);
        check("init_done", init_done, 1);
        check("upd_ready_run", upd_ready, 1);
        check("state_run", dbg_state, ST_RUN);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst_rdata", hash_rdata, 0);
        check("rst_rdata_wr", hash_rdata_wr, 0);
        check("rst_upd_err", upd_err, 0);
        check("rst_init_done", init_done, 0);
        check("rst_state", dbg_state, ST_CLEAR);
    endtask

    initial begin
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        idle(3);
        rst = 1'b0;
        rel_cyc = cyc;

        // Lookups during the sweep are dropped: the monitor expects no strobe.
        idle(5);
        hash_valid = 1'b1;
        idle(2);
        hash_valid = 1'b0;
        check("upd_ready_clear", upd_ready, 0);
        check("state_clear", dbg_state, ST_CLEAR);
        wait_init(rel_cyc);

        lookup(0, 0, 0, 0, 0, 0);
        lookup(534, 534, 534, 0, 0, 0);
        lookup(2139, 2139, 2139, 0, 0, 0);
        idle(3);

        upd(1, 100, UPD_WRITE, 4'h9, 1'b0);
        idle(3);
        lookup(100, 100, 100, 0, 4'h9, 0);

        repeat (5) upd(0, 7, UPD_INCR, 4'h0, 1'b0);
        idle(3);
        lookup(7, 7, 7, 4'h5, 0, 0);

        repeat (20) upd(2, 3, UPD_INCR, 4'h0, 1'b0);
        idle(3);
        lookup(3, 3, 3, 0, 0, INC20);

        upd(2, 600, UPD_WRITE, 4'h5, 1'b1);
        upd(3, 0, UPD_WRITE, 4'h1, 1'b1);
        upd(7, 5, UPD_WRITE, 4'h1, 1'b1);
        upd(0, 2140, UPD_WRITE, 4'h1, 1'b1);
        idle(3);
        lookup(2140, 0, 600, 0, 0, 0);

        upd(0, 2139, UPD_WRITE, 4'hA, 1'b0);
        upd(1, 1069, UPD_WRITE, 4'h6, 1'b0);
        upd(2, 534, UPD_WRITE, 4'hC, 1'b0);
        upd(1, 1070, UPD_WRITE, 4'h7, 1'b1);
        idle(3);
        lookup(2139, 1069, 534, 4'hA, 4'h6, 4'hC);
        lookup(2140, 1070, 535, 0, 0, 0);

        upd(0, 20, UPD_WRITE, 4'h7, 1'b0);
        upd(1, 20, UPD_WRITE, 4'h2, 1'b0);
        upd(0, 20, UPD_INCR, 4'h0, 1'b0);
        idle(3);
        lookup(20, 20, 20, 4'h8, 4'h2, 0);

        // Lookup sampled on the same edge as the update's write sees the old value.
        upd(1, 100, UPD_WRITE, 4'h3, 1'b0);
        idle(1);
        lookup(100, 100, 100, 0, 4'h9, 0);
        lookup(100, 100, 100, 0, 4'h3, 0);
        idle(5);
        check("drain_lookups", exp_q.size(), 0);
        check("drain_updates", exp_err_q.size(), 0);

        rst = 1'b1;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        idle(1000);
        check("midsweep_init_done", init_done, 0);
        check("midsweep_state", dbg_state, ST_CLEAR);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        rel_cyc = cyc;
        wait_init(rel_cyc);

        lookup(7, 100, 3, 0, 0, 0);
        lookup(2139, 1069, 534, 0, 0, 0);
        lookup(20, 20, 20, 0, 0, 0);
        idle(5);
        check("final_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
